// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: data width, the XZR index, the register
// address type and the bit positions of the ALU status flags.
package legv8_pkg;

   localparam int XLEN = 64;

   typedef logic [4:0] reg_addr_t;

   localparam reg_addr_t XZR_IDX = 5'd31;

   // Bit order matches the ALU status output, so status is stored verbatim
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

endpackage

// File: rtl/flags_reg_legv8.sv
// Condition-flag register: 4-bit enable-gated flop with async reset.
// With REGFILE_BYPASS_EN defined, the flag output forwards status_in while en is set.
module flags_reg_legv8
   import legv8_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       en,
   input  logic [3:0] status_in,
   output logic [3:0] flags
);

   logic [3:0] flags_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         flags_q <= '0;
      end else if (en) begin
         flags_q <= status_in;
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Reset still forces zero, so forwarding is held off while it is asserted
   assign flags = (en && !reset) ? status_in : flags_q;
`else
   assign flags = flags_q;
`endif

endmodule

// File: rtl/regfile_legv8.sv
// LEGv8 register file (31 writable 64-bit registers plus XZR) and flag register.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports and flags.
module regfile_legv8
   import legv8_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int NREGS = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  reg_addr_t        SA,
   input  reg_addr_t        SB,
   input  reg_addr_t        DA,
   input  logic             W,
   input  logic [WIDTH-1:0] D,
   input  logic             SL,
   input  logic [3:0]       status_in,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [3:0]       flags
);

   logic [WIDTH-1:0] rf [NREGS];
   logic             wr_en;

   // Writes aimed at XZR are dropped here, so the XZR entry only ever holds zero
   assign wr_en = W && (DA != XZR_IDX);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rf <= '{default: '0};
      end else if (wr_en) begin
         rf[DA] <= D;
      end
   end

   always_comb begin
      A = (SA == XZR_IDX) ? '0 : rf[SA];
      B = (SB == XZR_IDX) ? '0 : rf[SB];
`ifdef REGFILE_BYPASS_EN
      // DA is never XZR when wr_en is set, so XZR reads are never forwarded
      if (wr_en && !reset && (SA == DA)) A = D;
      if (wr_en && !reset && (SB == DA)) B = D;
`endif
   end

   flags_reg_legv8 u_flags (
      .clock     (clock),
      .reset     (reset),
      .en        (SL),
      .status_in (status_in),
      .flags     (flags)
   );

endmodule

// File: tb/tb_regfile_legv8.sv
// Directed bench for regfile_legv8: driver pushes expected A/B/flags into a queue,
// a negedge monitor pops and compares whenever a check is presented.
module tb_regfile_legv8;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [63:0] V1   = 64'h168630038235f585;
   localparam logic [63:0] V2   = 64'h0619fb057171e6e0;
   localparam logic [63:0] V30  = 64'h3030303030303030;
   localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

   logic        clock;
   logic        reset;
   logic [4:0]  SA, SB, DA;
   logic        W, SL;
   logic [63:0] D;
   logic [3:0]  status_in;
   logic [63:0] A, B;
   logic [3:0]  flags;

   logic [131:0] exp_q[$];
   string        name_q[$];
   logic         mon_valid;
   int           checks;
   int           errors;
   logic [63:0]  model [32];

   regfile_legv8 dut (
      .clock     (clock),
      .reset     (reset),
      .SA        (SA),
      .SB        (SB),
      .DA        (DA),
      .W         (W),
      .D         (D),
      .SL        (SL),
      .status_in (status_in),
      .A         (A),
      .B         (B),
      .flags     (flags)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic drive(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
                        input logic w, input logic [63:0] d, input logic sl,
                        input logic [3:0] st);
      @(posedge clock);
      #1;
      mon_valid = 1'b0;
      SA = sa;
      SB = sb;
      DA = da;
      W = w;
      D = d;
      SL = sl;
      status_in = st;
   endtask

   task automatic expect_out(input string nm, input logic [63:0] ea, input logic [63:0] eb,
                             input logic [3:0] ef);
      exp_q.push_back({ea, eb, ef});
      name_q.push_back(nm);
      mon_valid = 1'b1;
   endtask

   // scoreboard monitor
   always @(negedge clock) begin
      if (mon_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL monitor: output presented with empty expected queue");
         end else begin
            logic [131:0] e;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if ({A, B, flags} !== e) begin
               errors++;
               $display("FAIL %s: got A=%h B=%h flags=%b, expected A=%h B=%h flags=%b",
                        nm, A, B, flags, e[131:68], e[67:4], e[3:0]);
            end
         end
      end
   end

   // stimulus
   initial begin
      checks = 0;
      errors = 0;
      mon_valid = 1'b0;
      reset = 1'b0;
      SA = '0; SB = '0; DA = '0; W = 1'b0; D = '0; SL = 1'b0; status_in = '0;
      for (int i = 0; i < 32; i++) model[i] = '0;

      // asynchronous reset pulse entirely between edges
      drive(0, 0, 0, 0, 0, 0, 4'b0000);
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         drive(i[4:0], 5'(31 - i), 0, 0, 0, 0, 4'b0000);
         expect_out("reset_sweep", 64'd0, 64'd0, 4'b0000);
      end

      // write / read
      drive(0, 0, 1, 1, V1, 0, 4'b0000);
      expect_out("wr_x1", 64'd0, 64'd0, 4'b0000);
      drive(1, 3, 2, 1, V2, 0, 4'b0000);
      expect_out("wr_x2_rd_x1", V1, 64'd0, 4'b0000);
      drive(1, 2, 0, 0, 64'd0, 0, 4'b0000);
      expect_out("rd_x1_x2", V1, V2, 4'b0000);
      drive(0, 0, 30, 1, V30, 0, 4'b0000);
      expect_out("wr_x30", 64'd0, 64'd0, 4'b0000);

      // XZR writes discarded
      drive(31, 31, 31, 1, ONES, 0, 4'b0000);
      expect_out("xzr_wr", 64'd0, 64'd0, 4'b0000);
      drive(31, 30, 0, 0, 64'd0, 0, 4'b0000);
      expect_out("xzr_rd_x30", 64'd0, V30, 4'b0000);

      // same-cycle read of a register being written
      drive(0, 0, 5, 1, 64'd6, 0, 4'b0000);
      expect_out("preload_x5", 64'd0, 64'd0, 4'b0000);
      drive(5, 4, 5, 1, 64'd7, 0, 4'b0000);
      expect_out("same_cycle_x5", BYP ? 64'd7 : 64'd6, 64'd0, 4'b0000);
      drive(5, 5, 0, 0, 64'd0, 0, 4'b0000);
      expect_out("after_edge_x5", 64'd7, 64'd7, 4'b0000);

      model[1] = V1;
      model[2] = V2;
      model[5] = 64'd7;
      model[30] = V30;
      for (int i = 0; i < 32; i++) begin
         drive(i[4:0], i[4:0], 0, 0, 64'd0, 0, 4'b0000);
         expect_out("contents_sweep", model[i], model[i], 4'b0000);
      end

      // flags
      drive(0, 0, 0, 0, 64'd0, 1, 4'b1010);
      expect_out("flags_set", 64'd0, 64'd0, BYP ? 4'b1010 : 4'b0000);
      drive(0, 0, 0, 0, 64'd0, 0, 4'b0101);
      expect_out("flags_hold", 64'd0, 64'd0, 4'b1010);
      drive(7, 0, 7, 1, 64'd77, 1, 4'b0011);
      expect_out("w_and_sl", BYP ? 64'd77 : 64'd0, 64'd0, BYP ? 4'b0011 : 4'b1010);
      drive(7, 1, 0, 0, 64'd0, 0, 4'b0000);
      expect_out("w_and_sl_after", 64'd77, V1, 4'b0011);

      // reset dominates a pending write and flag update
      drive(3, 1, 3, 1, 64'hABCD, 1, 4'b1111);
      reset = 1'b1;
      expect_out("reset_mid", 64'd0, 64'd0, 4'b0000);
      drive(3, 1, 0, 0, 64'd0, 0, 4'b0000);
      reset = 1'b0;
      expect_out("reset_after_edge", 64'd0, 64'd0, 4'b0000);
      drive(3, 1, 3, 1, 64'hABCD, 0, 4'b0000);
      expect_out("rewrite_x3", BYP ? 64'hABCD : 64'd0, 64'd0, 4'b0000);
      drive(3, 1, 0, 0, 64'd0, 0, 4'b0000);
      expect_out("rewrite_x3_after", 64'hABCD, 64'd0, 4'b0000);

      drive(0, 0, 0, 0, 64'd0, 0, 4'b0000);
      @(negedge clock);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
      end

      // final report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_legv8.md
# regfile_legv8

LEGv8 register file and condition-flag register feeding operands A/B to the 64-bit ALU and accepting its result F and 4-bit status back as write-back. Holds 32 × 64-bit general registers, with X31 fixed as XZR, plus one 4-bit NZCV-style flag register. Sits directly upstream of the ALU operand inputs and downstream of its outputs in the single-cycle datapath.

## Interface
- `WIDTH`, 64, register data width
- `NREGS`, 32, number of architectural registers; index `NREGS-1` is XZR
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `SA`  in  5  read address, port A
- `SB`  in  5  read address, port B
- `DA`  in  5  write address
- `W`  in  1  register write enable
- `D`  in  64  write data (ALU F or memory data)
- `SL`  in  1  flag-set enable (S-suffixed instructions)
- `status_in`  in  4  ALU status, stored verbatim
- `A`  out  64  register[SA]
- `B`  out  64  register[SB]
- `flags`  out  4  latched condition flags

## Operation
- Reads are combinational: A = reg[SA], B = reg[SB].
- SA or SB = 31 always reads 0, regardless of writes.
- On a rising clock edge with W=1 and DA≠31: reg[DA] ← D. A write to DA=31 is discarded, with no side effect.
- On a rising clock edge with SL=1: flags ← status_in. SL=0 holds flags.
- W and SL are independent, and both may act on the same edge.
- Both read ports may address the same register and return identical values.
- No other state exists: no pending writes and no multi-cycle operations.

## Timing
- Reset asserted (asynchronously, without waiting for a clock edge):
  - all 31 writable registers clear to 0
  - flags clear to 4'b0000
  - A, B read 0 for every address
- Reset dominates: while reset=1, W and SL are ignored on every edge.
- Reset deasserting mid-cycle leaves the stored state at zero; the first write lands on the next rising edge with reset=0.
- Write latency: the value is visible on A/B after the capturing edge (same-cycle behaviour is set by the macro in Configuration).
- Flag latency: flags update one edge after SL/status_in are sampled.
- Read latency: zero cycles, combinational from SA/SB.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - if W=1 and DA≠31 and SA==DA, then A = D combinationally in the same cycle; likewise B when SB==DA
  - flags also bypass: when SL=1, flags = status_in combinationally
- `REGFILE_BYPASS_EN` undefined:
  - A/B/flags show stored values only, and the new value appears after the capturing edge
- XZR reads stay 0 in both builds; a bypass never forwards to address 31.

## Structure
- Shared package `legv8_pkg`:
  - `XLEN`=64
  - `XZR_IDX`=5'd31
  - register-address typedef `reg_addr_t` (5-bit)
  - flag bit positions `FLAG_Z`=0, `FLAG_N`=1, `FLAG_C`=2, `FLAG_V`=3 (matching ALU status order)
- One natural sub-module, `flags_reg_legv8`: a 4-bit enable-gated flop with async reset, plus the optional bypass mux.
- The register array and read muxes stay in the top-level module.

## Test plan
1. Reset: pulse reset asynchronously between clock edges, then sweep SA/SB over 0–31 → A=B=0 for all addresses, flags=0000.
2. Write/read: W=1, DA=1, D=64'h168630038235f585; next edge DA=2, D=64'h0619fb057171e6e0; then SA=1, SB=2 → A=168630038235f585, B=0619fb057171e6e0, with no other register disturbed.
3. XZR: W=1, DA=31, D=64'hFFFFFFFFFFFFFFFF, then SA=31 → A=0 in both builds; register 30 unchanged.
4. Same-cycle read/write: preload X5=64'd6, then W=1, DA=5, D=64'd7, SA=5 before the edge.
   - With `REGFILE_BYPASS_EN`: A=7.
   - Without it: A=6, then A=7 after the edge.
5. Flags: SL=1, status_in=4'b1010 → flags=1010 after the edge; SL=0, status_in=4'b0101 → flags stays 1010; W and SL asserted together → both update on the same edge.
6. Reset mid-operation: with X1 holding data and W=1, DA=3, D=64'hABCD, assert reset before the edge → after the edge X3=0, X1=0, flags=0; deassert reset and write again → data stored on the next edge.
